freelist_recover_ctrl: RTL and testbench

Sequencer in front of the 4-lane physical-register free list in the Rename stage. In normal operation it forwards the four RefTable free lanes unchanged. On a ROB recovery request it clears the free list, then rebuilds it by scanning every physical register and pushing each one not held by the committed map. Rename stays stalled until the rebuild is complete.

---
 rtl/freelist_recover_ctrl_pkg.sv | 21 ++
 rtl/freelist_recover_ctrl_if.sv | 54 +++++
 rtl/freelist_lane_compact.sv | 29 ++
 rtl/freelist_recover_ctrl.sv | 169 ++++++++++++++++
 tb/tb_freelist_recover_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/freelist_recover_ctrl_pkg.sv
// Shared types and constants for the free-list recovery sequencer.
package freelist_recover_ctrl_pkg;

    localparam int unsigned PREG_NUM  = 128;
    localparam int unsigned PREG_W    = 7;
    localparam int unsigned SCAN_W    = 5;
    localparam int unsigned GROUP_NUM = PREG_NUM / 4;

    typedef logic [PREG_W-1:0] preg_t;

    // Architectural r0 mapping; never handed back to the free list.
    localparam preg_t RSV_PREG = '0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClean = 2'd1,
        StScan  = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/freelist_recover_ctrl_if.sv
// Rename-side bus of the free-list recovery sequencer.
// Optional macro FREELIST_RECOVER_PERF_EN adds the RecoverCnt/StallCycCnt counters.
interface freelist_recover_ctrl_if;
    import freelist_recover_ctrl_pkg::*;

    logic                RecoverReq;
    logic [PREG_NUM-1:0] CommitMap;
    logic                InFreeAble1, InFreeAble2, InFreeAble3, InFreeAble4;
    preg_t               InFreeAddr1, InFreeAddr2, InFreeAddr3, InFreeAddr4;
    logic                FreeAble1, FreeAble2, FreeAble3, FreeAble4;
    preg_t               FreeAddr1, FreeAddr2, FreeAddr3, FreeAddr4;
    logic                FreeListClean;
    logic                RenameStall;
    logic                RecoverDone;
`ifdef FREELIST_RECOVER_PERF_EN
    logic [15:0]         RecoverCnt;
    logic [31:0]         StallCycCnt;

    modport master (
        output RecoverReq, CommitMap,
        output InFreeAble1, InFreeAble2, InFreeAble3, InFreeAble4,
        output InFreeAddr1, InFreeAddr2, InFreeAddr3, InFreeAddr4,
        input  FreeAble1, FreeAble2, FreeAble3, FreeAble4,
        input  FreeAddr1, FreeAddr2, FreeAddr3, FreeAddr4,
        input  FreeListClean, RenameStall, RecoverDone, RecoverCnt, StallCycCnt
    );
    modport slave (
        input  RecoverReq, CommitMap,
        input  InFreeAble1, InFreeAble2, InFreeAble3, InFreeAble4,
        input  InFreeAddr1, InFreeAddr2, InFreeAddr3, InFreeAddr4,
        output FreeAble1, FreeAble2, FreeAble3, FreeAble4,
        output FreeAddr1, FreeAddr2, FreeAddr3, FreeAddr4,
        output FreeListClean, RenameStall, RecoverDone, RecoverCnt, StallCycCnt
    );
`else
    modport master (
        output RecoverReq, CommitMap,
        output InFreeAble1, InFreeAble2, InFreeAble3, InFreeAble4,
        output InFreeAddr1, InFreeAddr2, InFreeAddr3, InFreeAddr4,
        input  FreeAble1, FreeAble2, FreeAble3, FreeAble4,
        input  FreeAddr1, FreeAddr2, FreeAddr3, FreeAddr4,
        input  FreeListClean, RenameStall, RecoverDone
    );
    modport slave (
        input  RecoverReq, CommitMap,
        input  InFreeAble1, InFreeAble2, InFreeAble3, InFreeAble4,
        input  InFreeAddr1, InFreeAddr2, InFreeAddr3, InFreeAddr4,
        output FreeAble1, FreeAble2, FreeAble3, FreeAble4,
        output FreeAddr1, FreeAddr2, FreeAddr3, FreeAddr4,
        output FreeListClean, RenameStall, RecoverDone
    );
`endif

endinterface

// File: rtl/freelist_lane_compact.sv
// Packs up to four valid pregs, in ascending lane order, into lanes 0..n-1.
module freelist_lane_compact
    import freelist_recover_ctrl_pkg::*;
(
    input  logic [3:0] raw_valid,
    input  preg_t      raw_addr [4],
    output logic [3:0] pack_valid,
    output preg_t      pack_addr [4]
);

    logic [2:0] slot;

    // Walk the lanes in order and drop each valid one into the next free slot.
    always_comb begin
        pack_valid = '0;
        slot       = '0;
        for (int k = 0; k < 4; k++) begin
            pack_addr[k] = '0;
        end
        for (int k = 0; k < 4; k++) begin
            if (raw_valid[k]) begin
                pack_valid[slot[1:0]] = 1'b1;
                pack_addr[slot[1:0]]  = raw_addr[k];
                slot                  = slot + 3'd1;
            end
        end
    end

endmodule

// File: rtl/freelist_recover_ctrl.sv
// Free-list recovery sequencer: passes RefTable frees through, and on a ROB recovery
// clears the free list and rebuilds it from a snapshot of the committed map.
// Optional macro FREELIST_RECOVER_PERF_EN adds recovery/stall performance counters.
module freelist_recover_ctrl
    import freelist_recover_ctrl_pkg::*;
(
    input logic                    Clk,
    input logic                    Rest,
    freelist_recover_ctrl_if.slave bus
);

    state_e              state_q, state_d;
    logic [SCAN_W-1:0]   scan_idx_q;
    logic [PREG_NUM-1:0] snap_q;
    logic [3:0]          in_able, grp_free, pack_able, able_d, able_q;
    preg_t               in_addr [4];
    preg_t               grp_addr [4];
    preg_t               pack_addr [4];
    preg_t               addr_d [4];
    preg_t               addr_q [4];
    logic                clean_d, clean_q, stall_d, stall_q, done_d, done_q;
    logic                scan_last;

    assign in_able    = {bus.InFreeAble4, bus.InFreeAble3, bus.InFreeAble2, bus.InFreeAble1};
    assign in_addr[0] = bus.InFreeAddr1;
    assign in_addr[1] = bus.InFreeAddr2;
    assign in_addr[2] = bus.InFreeAddr3;
    assign in_addr[3] = bus.InFreeAddr4;
    assign scan_last  = (scan_idx_q == SCAN_W'(GROUP_NUM - 1));

    // Free candidates of the current scan group; the reserved preg is never freed.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            grp_addr[k] = {scan_idx_q, 2'(k)};
            grp_free[k] = ~snap_q[grp_addr[k]] && (grp_addr[k] != RSV_PREG);
        end
    end

    freelist_lane_compact u_compact (
        .raw_valid  (grp_free),
        .raw_addr   (grp_addr),
        .pack_valid (pack_able),
        .pack_addr  (pack_addr)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Rest) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Next state; a recovery request restarts the rebuild from any state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StIdle;
            StClean: state_d = StScan;
            StScan:  state_d = scan_last ? StDone : StScan;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (bus.RecoverReq) state_d = StClean;
    end

    // Next output values; a request cycle emits no frees or pulses of its own.
    always_comb begin
        able_d  = '0;
        clean_d = 1'b0;
        stall_d = 1'b0;
        done_d  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            addr_d[k] = '0;
        end
        unique case (state_q)
            StIdle: begin
                able_d = in_able;
                for (int k = 0; k < 4; k++) begin
                    addr_d[k] = in_able[k] ? in_addr[k] : '0;
                end
            end
            StClean: begin
                clean_d = 1'b1;
                stall_d = 1'b1;
            end
            StScan: begin
                stall_d = 1'b1;
                able_d  = pack_able;
                addr_d  = pack_addr;
            end
            StDone: begin
                done_d  = 1'b1;
                stall_d = 1'b1;
            end
            default: ;
        endcase
        if (bus.RecoverReq) begin
            able_d  = '0;
            clean_d = 1'b0;
            done_d  = 1'b0;
            for (int k = 0; k < 4; k++) begin
                addr_d[k] = '0;
            end
        end
    end

    // Output registers.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            able_q  <= '0;
            clean_q <= 1'b0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                addr_q[k] <= '0;
            end
        end else begin
            able_q  <= able_d;
            addr_q  <= addr_d;
            clean_q <= clean_d;
            stall_q <= stall_d;
            done_q  <= done_d;
        end
    end

    // Snapshot and scan pointer; later CommitMap changes do not disturb a running scan.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            snap_q     <= '0;
            scan_idx_q <= '0;
        end else if (state_q == StClean) begin
            snap_q     <= bus.CommitMap;
            scan_idx_q <= '0;
        end else if (state_q == StScan) begin
            scan_idx_q <= scan_idx_q + SCAN_W'(1);
        end
    end

    assign bus.FreeAble1     = able_q[0];
    assign bus.FreeAble2     = able_q[1];
    assign bus.FreeAble3     = able_q[2];
    assign bus.FreeAble4     = able_q[3];
    assign bus.FreeAddr1     = addr_q[0];
    assign bus.FreeAddr2     = addr_q[1];
    assign bus.FreeAddr3     = addr_q[2];
    assign bus.FreeAddr4     = addr_q[3];
    assign bus.FreeListClean = clean_q;
    assign bus.RenameStall   = stall_q;
    assign bus.RecoverDone   = done_q;

`ifdef FREELIST_RECOVER_PERF_EN
    logic [15:0] recover_cnt_q;
    logic [31:0] stall_cyc_cnt_q;

    // Saturating recovery and stall-cycle counters.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            recover_cnt_q   <= '0;
            stall_cyc_cnt_q <= '0;
        end else begin
            if (bus.RecoverReq && (recover_cnt_q != '1)) recover_cnt_q <= recover_cnt_q + 16'd1;
            if (stall_q && (stall_cyc_cnt_q != '1)) stall_cyc_cnt_q <= stall_cyc_cnt_q + 32'd1;
        end
    end

    assign bus.RecoverCnt  = recover_cnt_q;
    assign bus.StallCycCnt = stall_cyc_cnt_q;
`endif

endmodule

// File: tb/tb_freelist_recover_ctrl.sv
// Bench for freelist_recover_ctrl: cycle model keyed on cycles-since-request plus
// directed literal checks of the rebuild sequence.
module tb_freelist_recover_ctrl;
    import freelist_recover_ctrl_pkg::*;

    logic Clk = 1'b0;
    logic Rest;
    always #5 Clk = ~Clk;

    freelist_recover_ctrl_if bus ();

    freelist_recover_ctrl dut (
        .Clk  (Clk),
        .Rest (Rest),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int free_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] dut_able();
        return {bus.FreeAble4, bus.FreeAble3, bus.FreeAble2, bus.FreeAble1};
    endfunction

    function automatic logic [27:0] dut_addr();
        return {bus.FreeAddr4, bus.FreeAddr3, bus.FreeAddr2, bus.FreeAddr1};
    endfunction

    // Model: frees of group g listed in ascending order, skipping r0 and held pregs.
    function automatic void group_lanes(input int g, input logic [127:0] s,
                                        output logic [3:0] a, output logic [27:0] ad);
        int n = 0;
        a  = '0;
        ad = '0;
        for (int p = 4 * g; p < 4 * g + 4; p++) begin
            if (p != 0 && !s[p]) begin
                a[n]          = 1'b1;
                ad[n*7 +: 7]  = 7'(p);
                n++;
            end
        end
    endfunction

    // cnt = cycles since the last accepted request (-1 when idle); 1 clean, 2..33 scan, 34 done.
    int           cnt = -1;
    logic         model_valid = 1'b0;
    logic [127:0] snap;
    logic [3:0]   e_able, in_a;
    logic [27:0]  e_addr, in_ad;
    logic         e_clean, e_stall, e_done;
    logic [15:0]  e_rcnt;
    logic [31:0]  e_scnt;

    always @(posedge Clk) begin
        in_a  = {bus.InFreeAble4, bus.InFreeAble3, bus.InFreeAble2, bus.InFreeAble1};
        in_ad = {bus.InFreeAddr4, bus.InFreeAddr3, bus.InFreeAddr2, bus.InFreeAddr1};
        if (Rest) begin
            cnt = -1; snap = '0; e_able = '0; e_addr = '0;
            e_clean = 0; e_stall = 0; e_done = 0; e_rcnt = '0; e_scnt = '0;
            model_valid = 1'b1;
        end else begin
            if (e_stall && e_scnt != 32'hFFFF_FFFF) e_scnt = e_scnt + 1;
            if (bus.RecoverReq) begin
                if (e_rcnt != 16'hFFFF) e_rcnt = e_rcnt + 1;
                e_stall = (cnt >= 0 && cnt <= 33);
                e_able = '0; e_addr = '0; e_clean = 0; e_done = 0;
                cnt = 0;
            end else if (cnt >= 0 && cnt <= 33) begin
                cnt++;
                e_able = '0; e_addr = '0; e_stall = 1;
                e_clean = (cnt == 1);
                e_done  = (cnt == 34);
                if (cnt == 1) snap = bus.CommitMap;
                if (cnt >= 2 && cnt <= 33) group_lanes(cnt - 2, snap, e_able, e_addr);
            end else begin
                cnt = -1;
                e_clean = 0; e_stall = 0; e_done = 0;
                e_able = in_a;
                e_addr = '0;
                for (int k = 0; k < 4; k++) if (in_a[k]) e_addr[k*7 +: 7] = in_ad[k*7 +: 7];
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge Clk) begin
        if (model_valid) begin
            check("lane_able", dut_able(), e_able);
            check("lane_addr", dut_addr(), e_addr);
            check("flags", {bus.FreeListClean, bus.RenameStall, bus.RecoverDone},
                  {e_clean, e_stall, e_done});
`ifdef FREELIST_RECOVER_PERF_EN
            check("recover_cnt", bus.RecoverCnt, e_rcnt);
            check("stall_cyc_cnt", bus.StallCycCnt, e_scnt);
`endif
            if (bus.RenameStall) free_seen += $countones(dut_able());
        end
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic set_lanes(input logic [3:0] a, input logic [27:0] ad);
        {bus.InFreeAble4, bus.InFreeAble3, bus.InFreeAble2, bus.InFreeAble1} = a;
        {bus.InFreeAddr4, bus.InFreeAddr3, bus.InFreeAddr2, bus.InFreeAddr1} = ad;
    endtask

    task automatic pulse_req();
        bus.RecoverReq = 1'b1;
        tick();
        bus.RecoverReq = 1'b0;
    endtask

    // Follows one rebuild from offset 1 after the request edge to offset 36.
    task automatic run_rebuild(input string tag, input int exp_frees, input int probe_off,
                               input logic [3:0] probe_able, input logic [27:0] probe_addr,
                               input int chg_off, input logic [127:0] chg_map);
        int clean_at = -1, done_at = -1, done_n = 0, drop_at = -1;
        free_seen = 0;
        for (int off = 1; off <= 36; off++) begin
            tick();
            if (off == chg_off) bus.CommitMap = chg_map;
            if (bus.FreeListClean && clean_at < 0) clean_at = off;
            if (bus.RecoverDone) begin done_n++; done_at = off; end
            if (!bus.RenameStall && drop_at < 0) drop_at = off;
            if (off == probe_off) begin
                check({tag, "_probe_able"}, dut_able(), probe_able);
                check({tag, "_probe_addr"}, dut_addr(), probe_addr);
            end
        end
        check({tag, "_clean_at"}, clean_at, 1);
        check({tag, "_done_at"}, done_at, 34);
        check({tag, "_done_count"}, done_n, 1);
        check({tag, "_stall_drop_at"}, drop_at, 35);
        check({tag, "_total_frees"}, free_seen, exp_frees);
    endtask

    initial begin
        int done_n;
        Rest = 1'b1;
        bus.RecoverReq = 1'b0;
        bus.CommitMap  = '0;
        set_lanes(4'b0000, '0);
        repeat (3) tick();
        check("reset_able", dut_able(), 4'b0000);
        check("reset_flags", {bus.FreeListClean, bus.RenameStall, bus.RecoverDone}, 3'b000);
        Rest = 1'b0;
        tick();

        // 1: pass-through, inactive lane addresses forced to 0.
        set_lanes(4'b0011, {7'h66, 7'h55, 7'd10, 7'd9});
        tick();
        check("t1_able", dut_able(), 4'b0011);
        check("t1_addr", dut_addr(), {7'd0, 7'd0, 7'd10, 7'd9});
        check("t1_stall", bus.RenameStall, 1'b0);
        set_lanes(4'b0000, '0);

        // 2: pregs 0..31 held; group 8 frees 32..35.
        bus.CommitMap = 128'hFFFF_FFFF;
        pulse_req();
        run_rebuild("t2", 96, 10, 4'b1111, {7'd35, 7'd34, 7'd33, 7'd32}, -1, '0);

        // 3: nothing held; r0 still never freed.
        bus.CommitMap = '0;
        pulse_req();
        run_rebuild("t3", 127, 2, 4'b0111, {7'd0, 7'd3, 7'd2, 7'd1}, -1, '0);

        // 4: pregs 4 and 6 held; a later CommitMap change must not affect the scan.
        bus.CommitMap = '0;
        bus.CommitMap[4] = 1'b1;
        bus.CommitMap[6] = 1'b1;
        pulse_req();
        run_rebuild("t4", 125, 3, 4'b0011, {7'd0, 7'd0, 7'd7, 7'd5}, 5, '1);

        // 5: restart mid-scan with a fresh snapshot.
        bus.CommitMap = 128'hFFFF_FFFF;
        pulse_req();
        repeat (11) tick();
        bus.CommitMap = '0;
        pulse_req();
        run_rebuild("t5", 127, 2, 4'b0111, {7'd0, 7'd3, 7'd2, 7'd1}, -1, '0);

        // 6: reset mid-scan returns to idle pass-through with no done pulse.
        pulse_req();
        repeat (6) tick();
        Rest = 1'b1;
        tick();
        check("t6_rst_able", dut_able(), 4'b0000);
        check("t6_rst_addr", dut_addr(), 28'd0);
        check("t6_rst_flags", {bus.FreeListClean, bus.RenameStall, bus.RecoverDone}, 3'b000);
        Rest = 1'b0;
        set_lanes(4'b0001, {7'd0, 7'd0, 7'd0, 7'd42});
        tick();
        check("t6_pass_able", dut_able(), 4'b0001);
        check("t6_pass_addr", dut_addr(), {7'd0, 7'd0, 7'd0, 7'd42});
        check("t6_pass_stall", bus.RenameStall, 1'b0);
        set_lanes(4'b0000, '0);
        done_n = 0;
        repeat (40) begin
            tick();
            if (bus.RecoverDone) done_n++;
        end
        check("t6_no_done", done_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
